axis_video_pattern_gen: RTL and testbench



---
 rtl/axis_video_pattern_gen.sv | 207 ++++++++++++++++++++
 tb/tb_axis_video_pattern_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_video_pattern_gen                                                     |
// | AXI4-Stream synthetic video source: ramps, checkerboard or LFSR pixels.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axis_video_pattern_gen #(
  parameter int P_DAT_WIDTH  = 8,
  parameter int P_IMG_WIDTH  = 200,
  parameter int P_IMG_HEIGHT = 200,
  parameter int P_HBLANK     = 4,
  parameter int P_VBLANK     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_enable,
  input  logic [1:0]             i_pattern,
  output logic [P_DAT_WIDTH-1:0] o_maxis_tdata,
  input  logic                   i_maxis_tready,
  output logic                   o_maxis_tvalid,
  output logic                   o_maxis_tuser,
  output logic                   o_maxis_tlast,
  output logic                   o_frame_done,
  output logic [15:0]            o_frame_cnt
);

  localparam int C_HW        = $clog2(P_IMG_WIDTH);
  localparam int C_VW        = $clog2(P_IMG_HEIGHT);
  localparam int C_CW0       = (C_HW > C_VW) ? C_HW : C_VW;
  // Counters are at least 16 bits so every pixel bit and h[3]/v[3] exist.
  localparam int C_CW        = (C_CW0 > 16) ? C_CW0 : 16;
  localparam int C_BLANK_MAX = (P_HBLANK > P_VBLANK) ? P_HBLANK : P_VBLANK;
  localparam int C_BW        = (C_BLANK_MAX > 1) ? $clog2(C_BLANK_MAX) : 1;

  localparam logic [15:0]     C_LFSR_SEED = 16'hACE1;
  localparam logic [C_CW-1:0] C_H_LAST    = C_CW'(P_IMG_WIDTH - 1);
  localparam logic [C_CW-1:0] C_V_LAST    = C_CW'(P_IMG_HEIGHT - 1);
  localparam logic [C_BW-1:0] C_HB_LAST   = C_BW'(P_HBLANK - 1);
  localparam logic [C_BW-1:0] C_VB_LAST   = C_BW'(P_VBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t                 r_state;
  logic [C_CW-1:0]        r_hcnt;
  logic [C_CW-1:0]        r_vcnt;
  logic [C_BW-1:0]        r_blank_cnt;
  logic [15:0]            r_lfsr;
  logic [1:0]             r_pattern;
  logic [P_DAT_WIDTH-1:0] r_tdata;
  logic                   r_tvalid;
  logic                   r_tuser;
  logic                   r_tlast;
  logic                   r_frame_done;
  logic [15:0]            r_frame_cnt;

  state_t                 w_state_nxt;
  logic [C_CW-1:0]        w_hcnt_nxt;
  logic [C_CW-1:0]        w_vcnt_nxt;
  logic [C_BW-1:0]        w_blank_nxt;
  logic [15:0]            w_lfsr_nxt;
  logic [1:0]             w_pattern_nxt;
  logic                   w_done_nxt;
  logic [15:0]            w_frame_cnt_nxt;
  logic                   w_start;
  logic                   w_accept;
  logic                   w_valid_nxt;
  logic [15:0]            w_lfsr_step;
  logic [P_DAT_WIDTH-1:0] w_pixel;

  assign w_accept    = r_tvalid & i_maxis_tready;
  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  always_comb begin
    w_state_nxt     = r_state;
    w_hcnt_nxt      = r_hcnt;
    w_vcnt_nxt      = r_vcnt;
    w_blank_nxt     = r_blank_cnt;
    w_lfsr_nxt      = r_lfsr;
    w_pattern_nxt   = r_pattern;
    w_done_nxt      = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;
    w_start         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          w_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_accept) begin
          w_lfsr_nxt = w_lfsr_step;
          if (r_hcnt != C_H_LAST) begin
            w_hcnt_nxt = r_hcnt + 1'b1;
          end else if (r_vcnt != C_V_LAST) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = r_vcnt + 1'b1;
            if (P_HBLANK != 0) begin
              w_state_nxt = S_HBLANK;
              w_blank_nxt = '0;
            end
          end else begin
            w_hcnt_nxt      = '0;
            w_vcnt_nxt      = '0;
            w_done_nxt      = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
            if (P_VBLANK != 0) begin
              w_state_nxt = S_VBLANK;
              w_blank_nxt = '0;
            end else if (i_enable) begin
              w_start = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_HBLANK: begin
        if (r_blank_cnt == C_HB_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_blank_nxt = '0;
        end else begin
          w_blank_nxt = r_blank_cnt + 1'b1;
        end
      end
      default: begin
        if (r_blank_cnt == C_VB_LAST) begin
          w_blank_nxt = '0;
          if (i_enable) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_blank_nxt = r_blank_cnt + 1'b1;
        end
      end
    endcase

    // A frame start overrides everything else from the same edge.
    if (w_start) begin
      w_state_nxt   = S_ACTIVE;
      w_hcnt_nxt    = '0;
      w_vcnt_nxt    = '0;
      w_lfsr_nxt    = C_LFSR_SEED;
      w_pattern_nxt = i_pattern;
    end
  end

  assign w_valid_nxt = (w_state_nxt == S_ACTIVE);

  // Outputs are registered from next-state values so they line up with the beat.
  always_comb begin
    w_pixel = '0;
    case (w_pattern_nxt)
      2'd0:    w_pixel = w_hcnt_nxt[P_DAT_WIDTH-1:0];
      2'd1:    w_pixel = w_vcnt_nxt[P_DAT_WIDTH-1:0];
      2'd2:    w_pixel = {P_DAT_WIDTH{w_hcnt_nxt[3] ^ w_vcnt_nxt[3]}};
      default: w_pixel = w_lfsr_nxt[P_DAT_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= S_IDLE;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_blank_cnt  <= '0;
      r_lfsr       <= C_LFSR_SEED;
      r_pattern    <= 2'd0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_vcnt       <= w_vcnt_nxt;
      r_blank_cnt  <= w_blank_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_pattern    <= w_pattern_nxt;
      r_tdata      <= w_valid_nxt ? w_pixel : '0;
      r_tvalid     <= w_valid_nxt;
      r_tuser      <= w_valid_nxt && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
      r_tlast      <= w_valid_nxt && (w_hcnt_nxt == C_H_LAST);
      r_frame_done <= w_done_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
    end
  end

  assign o_maxis_tdata  = r_tdata;
  assign o_maxis_tvalid = r_tvalid;
  assign o_maxis_tuser  = r_tuser;
  assign o_maxis_tlast  = r_tlast;
  assign o_frame_done   = r_frame_done;
  assign o_frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_video_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axis_video_pattern_gen                                                  |
// | Two generator configurations against a frame-timeline reference model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_axis_video_pattern_gen;

  localparam int M_IDLE = 0;
  localparam int M_BEAT = 1;
  localparam int M_GAPH = 2;
  localparam int M_GAPV = 3;
  localparam int C_PHASE_LEN = 1200;
  localparam int C_PHASES    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        en     [2];
  logic [1:0]  pat    [2];
  logic        rdy    [2];
  logic [7:0]  tdata  [2];
  logic        tvalid [2];
  logic        tuser  [2];
  logic        tlast  [2];
  logic        done   [2];
  logic [15:0] fcnt   [2];

  axis_video_pattern_gen #(
    .P_DAT_WIDTH(8), .P_IMG_WIDTH(4), .P_IMG_HEIGHT(3), .P_HBLANK(2), .P_VBLANK(3)
  ) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en[0]), .i_pattern(pat[0]),
    .o_maxis_tdata(tdata[0]), .i_maxis_tready(rdy[0]), .o_maxis_tvalid(tvalid[0]),
    .o_maxis_tuser(tuser[0]), .o_maxis_tlast(tlast[0]), .o_frame_done(done[0]),
    .o_frame_cnt(fcnt[0])
  );

  axis_video_pattern_gen #(
    .P_DAT_WIDTH(8), .P_IMG_WIDTH(16), .P_IMG_HEIGHT(16), .P_HBLANK(0), .P_VBLANK(0)
  ) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en[1]), .i_pattern(pat[1]),
    .o_maxis_tdata(tdata[1]), .i_maxis_tready(rdy[1]), .o_maxis_tvalid(tvalid[1]),
    .o_maxis_tuser(tuser[1]), .o_maxis_tlast(tlast[1]), .o_frame_done(done[1]),
    .o_frame_cnt(fcnt[1])
  );

  // Per-instance geometry and model state.
  int          W  [2] = '{4, 16};
  int          H  [2] = '{3, 16};
  int          HB [2] = '{2, 0};
  int          VB [2] = '{3, 0};
  int          mode      [2] = '{M_IDLE, M_IDLE};
  int          rem       [2] = '{0, 0};
  int          pidx      [2] = '{0, 0};
  int          mpat      [2] = '{0, 0};
  logic [15:0] mlfsr     [2] = '{16'hACE1, 16'hACE1};
  logic        exp_valid [2] = '{1'b0, 1'b0};
  logic        exp_done  [2] = '{1'b0, 1'b0};
  logic        after_rst [2] = '{1'b1, 1'b1};
  int          exp_cnt   [2] = '{0, 0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int   taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    for (int i = 0; i < 4; i++) fb ^= l[taps[i]-1];
    return {l[14:0], fb};
  endfunction

  function automatic logic [7:0] ref_pixel(input int p, input int h, input int v,
                                           input logic [15:0] l);
    case (p)
      0:       return 8'(h % 256);
      1:       return 8'(v % 256);
      2:       return (((h / 8) % 2) != ((v / 8) % 2)) ? 8'hFF : 8'h00;
      default: return l[7:0];
    endcase
  endfunction

  task automatic observe(input int k);
    int h, v;
    check($sformatf("u%0d.tvalid", k), 32'(tvalid[k]), 32'(exp_valid[k]));
    if (exp_valid[k]) begin
      h = pidx[k] % W[k];
      v = pidx[k] / W[k];
      check($sformatf("u%0d.tdata(%0d,%0d)", k, h, v), 32'(tdata[k]),
            32'(ref_pixel(mpat[k], h, v, mlfsr[k])));
      check($sformatf("u%0d.tuser", k), 32'(tuser[k]), 32'(pidx[k] == 0));
      check($sformatf("u%0d.tlast", k), 32'(tlast[k]), 32'(h == W[k] - 1));
    end
    if (after_rst[k]) begin
      check($sformatf("u%0d.rst_tdata", k), 32'(tdata[k]), 32'd0);
      check($sformatf("u%0d.rst_tuser", k), 32'(tuser[k]), 32'd0);
      check($sformatf("u%0d.rst_tlast", k), 32'(tlast[k]), 32'd0);
    end
    check($sformatf("u%0d.frame_done", k), 32'(done[k]), 32'(exp_done[k]));
    check($sformatf("u%0d.frame_cnt", k), 32'(fcnt[k]), 32'(exp_cnt[k]));
  endtask

  task automatic start_frame(input int k);
    mode[k]  = M_BEAT;
    pidx[k]  = 0;
    mpat[k]  = int'(pat[k]);
    mlfsr[k] = 16'hACE1;
  endtask

  // Advance the model across the coming clock edge using the inputs just driven.
  task automatic step(input int k);
    int m0;
    exp_done[k]  = 1'b0;
    after_rst[k] = 1'b0;
    if (!rstn) begin
      mode[k]      = M_IDLE;
      exp_valid[k] = 1'b0;
      exp_cnt[k]   = 0;
      after_rst[k] = 1'b1;
      return;
    end
    m0 = mode[k];
    if (m0 == M_IDLE) begin
      if (en[k]) start_frame(k);
    end else begin
      if (mode[k] == M_BEAT && rdy[k]) begin
        mlfsr[k] = lfsr_next(mlfsr[k]);
        if (pidx[k] == W[k] * H[k] - 1) begin
          exp_done[k] = 1'b1;
          exp_cnt[k]  = (exp_cnt[k] + 1) % 65536;
          mode[k]     = M_GAPV;
          rem[k]      = VB[k];
        end else begin
          pidx[k]++;
          if (pidx[k] % W[k] == 0) begin
            mode[k] = M_GAPH;
            rem[k]  = HB[k];
          end
        end
      end
      if (mode[k] == M_GAPH || mode[k] == M_GAPV) begin
        if (rem[k] > 0) rem[k]--;
        else if (mode[k] == M_GAPH) mode[k] = M_BEAT;
        else if (en[k]) start_frame(k);
        else mode[k] = M_IDLE;
      end
    end
    exp_valid[k] = (mode[k] == M_BEAT);
  endtask

  task automatic drive(input int c);
    int ph, pc;
    ph = c / C_PHASE_LEN;
    pc = c % C_PHASE_LEN;
    rstn = !(c < 3 || (ph == 5 && pc >= 700 && pc < 702));
    for (int k = 0; k < 2; k++) begin
      case (ph)
        0: begin en[k] = 1'b1; pat[k] = 2'd0; rdy[k] = 1'b1; end
        1: begin en[k] = 1'b1; pat[k] = 2'd1; rdy[k] = (pc % 2 == 0); end
        2: begin en[k] = 1'b1; pat[k] = 2'd3; rdy[k] = ($urandom % 4 != 0); end
        3: begin
          en[k]  = ($urandom % 16 != 0);
          pat[k] = 2'($urandom % 4);
          rdy[k] = ($urandom % 2 == 0);
        end
        4: begin
          en[k]  = (pc < 40);
          pat[k] = 2'($urandom % 4);
          rdy[k] = ($urandom % 2 == 0);
        end
        default: begin
          en[k]  = 1'b1;
          pat[k] = (pc < 500) ? 2'd2 : 2'($urandom % 4);
          rdy[k] = (pc >= 690 && pc < 702) ? 1'b0 : ($urandom % 8 != 0);
        end
      endcase
    end
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k]  = 1'b0;
      pat[k] = 2'd0;
      rdy[k] = 1'b0;
    end
    for (int c = 0; c < C_PHASES * C_PHASE_LEN; c++) begin
      @(negedge clk);
      observe(0);
      observe(1);
      drive(c);
      step(0);
      step(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
